fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//  Downstream drain stage for the 16x8 synchronous FIFO.
//  - Pops bytes through the FIFO read port (rd_en/dout/empty) whenever the FIFO is non-empty.
//  - Serialises each byte as an async UART frame on tx: start bit, 8 data bits LSB first,
//    optional parity, stop bit(s).
//  - Sits between the FIFO read side and the chip pad.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal range >= 2.
//  STOP_BITS     1   number of stop bits; legal values 1 or 2.
// PORTS
//  clk         in   1  system clock; every flop is on its rising edge.
//  rst         in   1  reset, synchronous and active-high.
//  fifo_empty  in   1  FIFO empty flag.
//  fifo_rd_en  out  1  FIFO read strobe; exactly one cycle per byte.
//  fifo_dout   in   8  FIFO read data; valid the cycle after fifo_rd_en.
//  tx          out  1  serial line; idles high.
//  busy        out  1  high whenever state != IDLE.
//  frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit.
// BEHAVIOUR
//  Reset values:
//  - rst sampled high -> next cycle: state=IDLE, tx=1, busy=0, frame_done=0.
//  - Counters and shift register clear to 0.
//  fifo_rd_en:
//  - Combinational: (state==IDLE) && !fifo_empty && !rst.
//  - Never asserted in any other state, so at most one byte is in flight.
//  FSM (registered state; tx registered):
//  - IDLE   : tx=1. If fifo_rd_en -> LOAD.
//  - LOAD   : one cycle; shreg<=fifo_dout; tx<=0 -> START.
//  - START  : tx=0 for CLKS_PER_BIT cycles -> DATA.
//  - DATA   : tx=shreg[0]; shift right every CLKS_PER_BIT cycles; 8 bits -> PARITY or STOP.
//  - PARITY : present only with the macro; tx=^data for CLKS_PER_BIT cycles -> STOP.
//  - STOP   : tx=1 for STOP_BITS*CLKS_PER_BIT cycles; frame_done on final cycle -> IDLE.
//  Counters and widths:
//  - baud_cnt is $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1; bit advance on terminal count.
//  - bit_cnt is 3 bits and wraps 7->0 exactly at the DATA->next-state transition.
//  - Stop counter is sized for 2*CLKS_PER_BIT.
//  Latency:
//  - fifo_rd_en high in cycle N -> tx first low in cycle N+2.
//  - Every bit is held exactly CLKS_PER_BIT cycles, with no jitter.
//  Back-to-back operation:
//  - FIFO non-empty at frame end -> IDLE re-fetches immediately.
//  - Inter-frame gap is exactly 2 extra high cycles (IDLE + LOAD).
//  Boundary conditions:
//  - Empty FIFO holds the block in IDLE with tx=1 and no reads.
//  - fifo_empty changes mid-frame are ignored.
//  - The FIFO's own full flag has no effect here.
//  - rst mid-frame aborts the frame: tx=1 next cycle and the byte in flight is dropped.
//    FIFO pointers are not touched by this block.
//  - rst coinciding with a would-be fetch suppresses fifo_rd_en, so no byte is lost.
// CONFIGURATION
//  UART_TX_PARITY_EN
//  - Defined: PARITY state is compiled in; even parity bit follows D7.
//    Frame length is 11 bits (STOP_BITS=1) or 12 bits (STOP_BITS=2).
//  - Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.
//    Frame length is 10 or 11 bits.
// TESTING (CLKS_PER_BIT=4, STOP_BITS=1 unless noted)
//  1. FIFO holds 0xA5, no parity -> one rd_en pulse; tx: 0,1,0,1,0,0,1,0,1,1
//     (each level 4 cycles); frame_done once; tx low 2 cycles after rd_en.
//  2. Push 0x00, 0xFF, 0x3C -> three frames in order; 2-cycle high gap between frames;
//     3 rd_en pulses; busy drops after the 3rd stop bit.
//  3. FIFO empty for 100 cycles -> fifo_rd_en=0, tx=1, busy=0 throughout.
//  4. Assert rst for 1 cycle mid-DATA of 0x81 -> tx=1 next cycle, state IDLE;
//     the next queued byte 0x42 is sent intact.
//  5. UART_TX_PARITY_EN defined, bytes 0x07 then 0x03 -> parity bits 1 then 0;
//     frame 44 cycles of line time each.
//  6. STOP_BITS=2, byte 0x55 -> stop high 8 cycles; frame_done on cycle 8 of stop.

Source files
------------

// File: rtl/fifo_uart_tx_if.sv
// fifo_uart_tx_if
// Groups the FIFO read port and the serial-side status outputs of the UART
// transmitter into one bundle. clk and rst are not part of the bundle.
//
// Signals:
//   fifo_empty  FIFO empty flag (FIFO -> transmitter)
//   fifo_dout   FIFO read data, valid the cycle after fifo_rd_en (FIFO -> transmitter)
//   fifo_rd_en  one-cycle FIFO read strobe per byte (transmitter -> FIFO)
//   tx          serial line, idles high
//   busy        transmitter is not idle
//   frame_done  pulse on the last cycle of the final stop bit
//
// Modports:
//   master  the transmitter (drains the FIFO, drives the line)
//   slave   the FIFO / environment side
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    input  fifo_empty,
    input  fifo_dout,
    output fifo_rd_en,
    output tx,
    output busy,
    output frame_done
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    input  fifo_rd_en,
    input  tx,
    input  busy,
    input  frame_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drain stage for a 16x8 synchronous FIFO: pops one byte at a time whenever
// the FIFO is non-empty and serialises it as an async UART frame on tx
// (start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports:
//   clk   system clock, all flops on its rising edge
//   rst   synchronous active-high reset
//   bus   fifo_uart_tx_if.master: fifo_empty, fifo_dout in;
//         fifo_rd_en, tx, busy, frame_done out
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even parity bit is sent after D7.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input logic            clk,
  input logic            rst,
  fifo_uart_tx_if.master bus
);

  localparam int BW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SW       = $clog2(2 * CLKS_PER_BIT);
  localparam int STOP_LEN = STOP_BITS * CLKS_PER_BIT;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [SW-1:0] STOP_LAST = SW'(STOP_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [SW-1:0] stop_cnt;
  logic [7:0]    shreg;
  logic          tx_q;
  logic          rd_en;
  logic          baud_done;
  logic          stop_done;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  assign baud_done = (baud_cnt == BAUD_LAST);
  assign stop_done = (stop_cnt == STOP_LAST);

  // A fetch is only ever issued from IDLE, so at most one byte is in flight;
  // rst gates it so a reset cycle never consumes a byte that would be lost.
  assign rd_en = (state == IDLE) && !bus.fifo_empty && !rst;

  assign bus.fifo_rd_en = rd_en;
  assign bus.tx         = tx_q;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = (state == STOP) && stop_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (rd_en) state_next = LOAD;
      LOAD:  state_next = START;
      START: if (baud_done) state_next = DATA;
      DATA: begin
        if (baud_done && (bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_done) state_next = STOP;
`endif
      STOP:  if (stop_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx is registered, so each state's line level is loaded on the edge that
  // enters the state; this keeps every bit exactly CLKS_PER_BIT cycles wide.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q     <= 1'b1;
      shreg    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx_q     <= 1'b1;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          stop_cnt <= '0;
        end
        LOAD: begin
          shreg    <= bus.fifo_dout;
          tx_q     <= 1'b0;
          baud_cnt <= '0;
`ifdef UART_TX_PARITY_EN
          parity_bit <= ^bus.fifo_dout;
`endif
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx_q     <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q <= parity_bit;
`else
              tx_q <= 1'b1;
`endif
            end else begin
              // The next bit is shreg[1] now, shreg[0] after the shift.
              shreg <= {1'b0, shreg[7:1]};
              tx_q  <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            tx_q     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          tx_q <= 1'b1;
          if (stop_done) begin
            stop_cnt <= '0;
          end else begin
            stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          tx_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx
// Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4, STOP_BITS=1.
// The bench owns a byte-queue FIFO and a line-level reference model: every
// fetched byte is expanded into the expected per-cycle tx/frame_done levels,
// which are compared with the DUT every cycle together with busy and rd_en.
module tb_fifo_uart_tx;

  localparam int CLKS_PER_BIT = 4;
  localparam int STOP_BITS    = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS     = 1;
  localparam int LINE_TIME    = 44;
`else
  localparam int PAR_BITS     = 0;
  localparam int LINE_TIME    = 40;
`endif
  localparam int FRAME_BITS   = 1 + 8 + PAR_BITS + STOP_BITS;

  typedef struct packed {
    logic tx;
    logic done;
  } line_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic check_en = 1'b0;
  logic tb_empty = 1'b1;
  logic [7:0] tb_dout = 8'h00;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo_q[$];
  line_t      line_q[$];

  int cyc = 0;
  int rd_cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  logic pend = 1'b0;
  int last_lat = 0;
  int last_line_time = 0;
  int last_gap = 0;
  int rd_count = 0;
  int done_count = 0;

  always #5 clk = ~clk;

  fifo_uart_tx_if bus();

  assign bus.fifo_empty = tb_empty;
  assign bus.fifo_dout  = tb_dout;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .STOP_BITS   (STOP_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // Line levels of one frame, LSB = first bit on the wire; bits past the
  // frame are left high so the stop bits come out as ones.
  function automatic logic [15:0] frameLevels(input logic [7:0] d);
    logic [15:0] lv;
    lv    = '1;
    lv[0] = 1'b0;
    for (int i = 0; i < 8; i++) lv[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
    lv[9] = ^d;
`endif
    return lv;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic pushFrame(input logic [7:0] d);
    logic [15:0] lv;
    lv = frameLevels(d);
    line_q.push_back('{tx: 1'b1, done: 1'b0});
    for (int b = 0; b < FRAME_BITS; b++) begin
      for (int c = 0; c < CLKS_PER_BIT; c++) begin
        line_q.push_back('{tx: lv[b], done: (b == FRAME_BITS - 1) && (c == CLKS_PER_BIT - 1)});
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d);
    fifo_q.push_back(d);
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || !tb_empty || bus.busy || line_q.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) checkOutput("wait_idle_timeout", 32'd1, 32'd0);
    tick(3);
  endtask

  // Bench FIFO: registered read data and empty flag, like the real 16x8 FIFO.
  always @(posedge clk) begin
    if (bus.fifo_rd_en && fifo_q.size() > 0) tb_dout <= fifo_q.pop_front();
    tb_empty <= (fifo_q.size() == 0);
  end

  // Compare process: one expected line entry per busy cycle, idle otherwise.
  always @(negedge clk) begin : compare
    line_t e;
    logic  idle_now;
    logic  exp_rd;
    if (check_en) begin
      idle_now = (line_q.size() == 0);
      if (idle_now) e = '{tx: 1'b1, done: 1'b0};
      else          e = line_q.pop_front();
      exp_rd = idle_now && !tb_empty && !rst;
      checkOutput("tx", 32'(bus.tx), 32'(e.tx));
      checkOutput("busy", 32'(bus.busy), 32'(!idle_now));
      checkOutput("frame_done", 32'(bus.frame_done), 32'(e.done));
      checkOutput("fifo_rd_en", 32'(bus.fifo_rd_en), 32'(exp_rd));
      if (rst) line_q.delete();
      else if (exp_rd && fifo_q.size() > 0) pushFrame(fifo_q[0]);
    end
  end

  // Timing monitor for latency, line time and inter-frame gap.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pend = 1'b0;
    end else if (bus.fifo_rd_en) begin
      rd_count++;
      rd_cyc = cyc;
      pend   = 1'b1;
    end else if (pend && bus.tx == 1'b0) begin
      pend      = 1'b0;
      last_lat  = cyc - rd_cyc;
      last_gap  = cyc - done_cyc - 1;
      start_cyc = cyc;
    end
    if (bus.frame_done) begin
      done_count++;
      done_cyc       = cyc;
      last_line_time = cyc - start_cyc + 1;
    end
  end

  initial begin
    int rd0;
    int dn0;
    int n;
    logic [15:0] lv;

    rst = 1'b1;
    tick(1);
    check_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);

    // Model pins against hand-computed frames.
    lv = frameLevels(8'hA5);
`ifdef UART_TX_PARITY_EN
    checkOutput("model_a5_levels", 32'(lv[10:0]), 32'(11'b10101001010));
    lv = frameLevels(8'h07);
    checkOutput("model_parity_07", 32'(lv[9]), 32'd1);
    lv = frameLevels(8'h03);
    checkOutput("model_parity_03", 32'(lv[9]), 32'd0);
`else
    checkOutput("model_a5_levels", 32'(lv[9:0]), 32'(10'b1101001010));
`endif

    // Single byte 0xA5.
    applyStimulus(8'hA5);
    waitIdle(200);
    checkOutput("t1_rd_count", 32'(rd_count), 32'd1);
    checkOutput("t1_done_count", 32'(done_count), 32'd1);
    checkOutput("t1_latency", 32'(last_lat), 32'd2);
    checkOutput("t1_line_time", 32'(last_line_time), 32'(LINE_TIME));

    // Back-to-back frames.
    rd0 = rd_count;
    dn0 = done_count;
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h3C);
    waitIdle(400);
    checkOutput("t2_rd_count", 32'(rd_count - rd0), 32'd3);
    checkOutput("t2_done_count", 32'(done_count - dn0), 32'd3);
    checkOutput("t2_gap", 32'(last_gap), 32'd2);

    // Empty FIFO for 100 cycles.
    rd0 = rd_count;
    tick(100);
    checkOutput("t3_no_reads", 32'(rd_count - rd0), 32'd0);

    // Reset mid-DATA of 0x81; 0x42 must follow intact.
    rd0 = rd_count;
    dn0 = done_count;
    applyStimulus(8'h81);
    applyStimulus(8'h42);
    n = 0;
    while (rd_count == rd0 && n < 50) begin
      tick(1);
      n++;
    end
    if (n >= 50) checkOutput("t4_fetch_timeout", 32'd1, 32'd0);
    tick(2 + CLKS_PER_BIT + 5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    waitIdle(300);
    checkOutput("t4_rd_count", 32'(rd_count - rd0), 32'd2);
    checkOutput("t4_done_count", 32'(done_count - dn0), 32'd1);

    // Bytes 0x07 and 0x03 (parity 1 then 0 when parity is built in).
    applyStimulus(8'h07);
    applyStimulus(8'h03);
    waitIdle(300);
    checkOutput("t5_line_time", 32'(last_line_time), 32'(LINE_TIME));

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (fifo_q.size() < 16 && $urandom_range(0, 7) == 0) applyStimulus(8'($urandom));
      rst = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rst = 1'b0;
    waitIdle(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
